// File: rtl/controller_poll_sequencer.sv
// controller_poll_sequencer: polls a serial game pad and exposes its buttons over APB.
// A poll is a latch strobe followed by NUM_BITS shift-clock windows; each bit is
// sampled from the active-low contREAD line at the end of its low window.
// Optional build macro CONT_DEBOUNCE_EN: only publish a sample that matches the
// previous completed sample.
module controller_poll_sequencer #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned POLL_PERIOD = 1000,
    parameter int unsigned NUM_BITS    = 8
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [3:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    input  logic        contREAD,
    output logic        contLATCH,
    output logic        contCLK,
    output logic        IRQ
);

    localparam int unsigned PHASE_W  = $clog2(2 * CLK_DIV);
    localparam int unsigned PERIOD_W = $clog2(POLL_PERIOD);
    localparam int unsigned IDX_W    = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        LOW   = 3'd2,
        HIGH  = 3'd3,
        DONE  = 3'd4
    } pollState_t;

    pollState_t state;
    pollState_t nextState;

    logic [PHASE_W-1:0]  phaseCnt;
    logic [PERIOD_W-1:0] periodCnt;
    logic [IDX_W-1:0]    bitIdx;
    logic [NUM_BITS-1:0] sampleReg;
    logic [NUM_BITS-1:0] buttons;
    logic                ctrlEn;
    logic                ctrlIrqEn;
    logic                newFlag;

    logic apbWr;
    logic wrCtrl;
    logic wrStatus;
    logic trigReq;
    logic newClr;
    logic tick;
    logic pollStart;
    logic latchLast;
    logic halfLast;
    logic bitLast;

    logic latchD;
    logic clkD;
    logic sampleEn;
    logic advanceEn;
    logic commitEn;
    logic busy;

    logic unusedApb;

    // APB decode and poll-start qualification
    assign apbWr     = PSEL & PENABLE & PWRITE;
    assign wrCtrl    = apbWr & (PADDR[3:2] == 2'd0);
    assign wrStatus  = apbWr & (PADDR[3:2] == 2'd1);
    assign trigReq   = wrCtrl & PWDATA[1];
    assign newClr    = wrStatus & PWDATA[1];
    assign tick      = (periodCnt == '0);
    assign pollStart = (state == IDLE) & (trigReq | (tick & ctrlEn));
    assign latchLast = (phaseCnt == PHASE_W'(2 * CLK_DIV - 1));
    assign halfLast  = (phaseCnt == PHASE_W'(CLK_DIV - 1));
    assign bitLast   = (bitIdx == IDX_W'(NUM_BITS - 1));
    assign PREADY    = 1'b1;
    assign unusedApb = ^{PADDR[1:0], PWDATA[31:3]};

    // FSM state register
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // FSM next-state logic
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (pollStart) nextState = LATCH;
            LATCH:   if (latchLast) nextState = LOW;
            LOW:     if (halfLast)  nextState = bitLast ? DONE : HIGH;
            HIGH:    if (halfLast)  nextState = LOW;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // FSM outputs: strobe targets come from the next state so the registered strobes align with it
    always_comb begin
        latchD    = 1'b0;
        clkD      = 1'b0;
        sampleEn  = 1'b0;
        advanceEn = 1'b0;
        busy      = 1'b1;
        latchD    = (nextState == LATCH);
        clkD      = (nextState == HIGH);
        sampleEn  = (state == LOW) & halfLast;
        advanceEn = (state == HIGH) & halfLast;
        busy      = (state != IDLE);
    end

`ifdef CONT_DEBOUNCE_EN
    logic [NUM_BITS-1:0] prevSample;

    // Publish only when two consecutive completed samples agree
    assign commitEn = (state == DONE) & (sampleReg == prevSample);

    // Remember the last completed sample, published or not
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            prevSample <= '0;
        end else if (state == DONE) begin
            prevSample <= sampleReg;
        end
    end
`else
    assign commitEn = (state == DONE);
`endif

    // Phase timer, bit index and sample shift register
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            phaseCnt  <= '0;
            bitIdx    <= '0;
            sampleReg <= '0;
        end else begin
            if (state != nextState) begin
                phaseCnt <= '0;
            end else begin
                phaseCnt <= phaseCnt + PHASE_W'(1);
            end
            if (pollStart) begin
                bitIdx    <= '0;
                sampleReg <= '0;
            end else begin
                if (advanceEn) begin
                    bitIdx <= bitIdx + IDX_W'(1);
                end
                if (sampleEn) begin
                    sampleReg[bitIdx] <= ~contREAD;
                end
            end
        end
    end

    // Registered pad strobes
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            contLATCH <= 1'b0;
            contCLK   <= 1'b0;
        end else begin
            contLATCH <= latchD;
            contCLK   <= clkD;
        end
    end

    // Free-running poll period counter
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            periodCnt <= PERIOD_W'(POLL_PERIOD - 1);
        end else if (tick) begin
            periodCnt <= PERIOD_W'(POLL_PERIOD - 1);
        end else begin
            periodCnt <= periodCnt - PERIOD_W'(1);
        end
    end

    // Software-visible registers and interrupt; a DONE set beats a same-cycle clear
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            ctrlEn    <= 1'b0;
            ctrlIrqEn <= 1'b0;
            newFlag   <= 1'b0;
            buttons   <= '0;
            IRQ       <= 1'b0;
        end else begin
            if (wrCtrl) begin
                ctrlEn    <= PWDATA[0];
                ctrlIrqEn <= PWDATA[2];
            end
            if (commitEn) begin
                buttons <= sampleReg;
                newFlag <= 1'b1;
            end else if (newClr) begin
                newFlag <= 1'b0;
            end
            IRQ <= newFlag & ctrlIrqEn;
        end
    end

    // Combinational read mux
    always_comb begin
        PRDATA = '0;
        case (PADDR[3:2])
            2'd0:    PRDATA = {29'd0, ctrlIrqEn, 1'b0, ctrlEn};
            2'd1:    PRDATA = {30'd0, newFlag, busy};
            2'd2:    PRDATA = 32'(buttons);
            default: PRDATA = '0;
        endcase
    end

endmodule

// File: tb/tb_controller_poll_sequencer.sv
// Testbench for controller_poll_sequencer: pad model plus a register-level reference model.
module tb_controller_poll_sequencer;

    localparam int unsigned CLK_DIV     = 4;
    localparam int unsigned POLL_PERIOD = 200;
    localparam int unsigned NUM_BITS    = 8;
    localparam int unsigned POLL_LEN    = 2 * CLK_DIV + NUM_BITS * CLK_DIV + (NUM_BITS - 1) * CLK_DIV + 1;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [3:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        contREAD;
    logic        contLATCH;
    logic        contCLK;
    logic        IRQ;

    controller_poll_sequencer #(
        .CLK_DIV    (CLK_DIV),
        .POLL_PERIOD(POLL_PERIOD),
        .NUM_BITS   (NUM_BITS)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .contREAD (contREAD),
        .contLATCH(contLATCH),
        .contCLK  (contCLK),
        .IRQ      (IRQ)
    );

    always #5 PCLK = ~PCLK;

    // Pad model: latch loads the pressed pattern, each shift-clock rise advances one bit
    logic [NUM_BITS-1:0] directPattern = '0;
    logic [NUM_BITS-1:0] padShift = '0;
    logic                randPad = 1'b0;
    logic [NUM_BITS-1:0] patQ[$];

    always @(posedge contCLK or posedge contLATCH) begin
        if (contLATCH) begin
            padShift = randPad ? NUM_BITS'($urandom) : directPattern;
            patQ.push_back(padShift);
        end else begin
            padShift = padShift >> 1;
        end
    end
    assign contREAD = ~padShift[0];

    // Poll-start monitor
    int   cyc = 0;
    int   totalStarts = 0;
    logic latchPrev = 1'b0;
    int   latchStarts[$];

    always @(posedge PCLK) cyc++;

    always @(negedge PCLK) begin
        if (contLATCH && !latchPrev) begin
            latchStarts.push_back(cyc);
            totalStarts++;
        end
        latchPrev = contLATCH;
    end

    // Reference model state
    logic [NUM_BITS-1:0] mButtons;
    logic                mNew;
    logic                mIrqEn;
    logic                mEn;
`ifdef CONT_DEBOUNCE_EN
    logic [NUM_BITS-1:0] mPrev;
`endif
    int expStarts = 0;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mButtons = '0;
        mNew     = 1'b0;
        mIrqEn   = 1'b0;
        mEn      = 1'b0;
`ifdef CONT_DEBOUNCE_EN
        mPrev    = '0;
`endif
    endtask

    task automatic modelPoll(input logic [NUM_BITS-1:0] s);
`ifdef CONT_DEBOUNCE_EN
        if (s == mPrev) begin
            mButtons = s;
            mNew     = 1'b1;
        end
        mPrev = s;
`else
        mButtons = s;
        mNew     = 1'b1;
`endif
    endtask

    task automatic popPattern(output logic [NUM_BITS-1:0] p);
        chk("pattern_queue", 32'(patQ.size() > 0), 32'd1);
        if (patQ.size() > 0) p = patQ.pop_front();
        else p = '0;
    endtask

    // Two-phase APB write; called at a negedge, returns at the negedge after the write edge
    task automatic apbWrite(input logic [3:0] addr, input logic [31:0] data);
        PSEL    = 1'b1;
        PWRITE  = 1'b1;
        PENABLE = 1'b0;
        PADDR   = addr;
        PWDATA  = data;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
    endtask

    task automatic apbRead(input logic [3:0] addr, output logic [31:0] data);
        PADDR = addr;
        #1;
        data = PRDATA;
    endtask

    task automatic doReset();
        PRESET = 1'b1;
        repeat (3) @(negedge PCLK);
        PRESET = 1'b0;
        modelReset();
    endtask

    task automatic checkRegs();
        logic [31:0] rd;
        apbRead(4'h8, rd);
        chk("buttons", rd, 32'(mButtons));
        apbRead(4'h4, rd);
        chk("status", rd, {30'd0, mNew, 1'b0});
        apbRead(4'h0, rd);
        chk("ctrl", rd, {29'd0, mIrqEn, 1'b0, mEn});
        chk("irq", 32'(IRQ), 32'(mNew & mIrqEn));
    endtask

    task automatic runTrigPoll(input logic irqEn);
        logic [NUM_BITS-1:0] p;
        apbWrite(4'h0, {29'd0, irqEn, 1'b1, mEn});
        mIrqEn = irqEn;
        expStarts++;
        repeat (POLL_LEN) @(negedge PCLK);
        popPattern(p);
        modelPoll(p);
        @(negedge PCLK);
        checkRegs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [NUM_BITS-1:0] p;
        logic [NUM_BITS-1:0] seq6[3];
        int latchCyc, clkRise, clkHigh, lowCyc, busyCyc, both, firstNew, rises;
        logic prevC, irqBefore;

        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0;
        modelReset();
        @(negedge PCLK);

        // Reset state
        doReset();
        chk("rst_latch", 32'(contLATCH), 32'd0);
        chk("rst_clk", 32'(contCLK), 32'd0);
        chk("rst_irq", 32'(IRQ), 32'd0);
        chk("rst_pready", 32'(PREADY), 32'd1);
        apbRead(4'h0, rd); chk("rst_ctrl", rd, 32'd0);
        apbRead(4'h4, rd); chk("rst_status", rd, 32'd0);
        apbRead(4'h8, rd); chk("rst_buttons", rd, 32'd0);
        apbRead(4'hC, rd); chk("rst_reserved", rd, 32'd0);

        // Triggered poll: strobe shape and latency
        directPattern = 8'b1010_0101;
        apbWrite(4'h0, 32'h2);
        expStarts++;
        latchCyc = 0; clkRise = 0; clkHigh = 0; lowCyc = 0; busyCyc = 0;
        both = 0; firstNew = -1; prevC = 1'b0;
        for (int k = 0; k < int'(POLL_LEN) + 10; k++) begin
            apbRead(4'h4, rd);
            if (rd[0]) busyCyc++;
            if (rd[1] && firstNew < 0) firstNew = k;
            if (contLATCH) latchCyc++;
            if (contCLK) clkHigh++;
            if (contCLK && !prevC) clkRise++;
            if (contLATCH && contCLK) both++;
            if (rd[0] && !contLATCH && !contCLK) lowCyc++;
            prevC = contCLK;
            if (k == 30) begin
                apbRead(4'h8, rd);
                chk("buttons_midpoll", rd, 32'(mButtons));
            end
            @(negedge PCLK);
        end
        popPattern(p);
        modelPoll(p);
        chk("latch_cycles", 32'(latchCyc), 32'(2 * CLK_DIV));
        chk("clk_pulses", 32'(clkRise), 32'(NUM_BITS - 1));
        chk("clk_high_cycles", 32'(clkHigh), 32'((NUM_BITS - 1) * CLK_DIV));
        chk("low_cycles", 32'(lowCyc), 32'(NUM_BITS * CLK_DIV + 1));
        chk("strobe_overlap", 32'(both), 32'd0);
        chk("busy_cycles", 32'(busyCyc), 32'(POLL_LEN));
        chk("new_latency", 32'(firstNew), mNew ? 32'(POLL_LEN) : 32'hFFFF_FFFF);
        checkRegs();

        // Interrupt set and clear
        apbWrite(4'h4, 32'h2); mNew = 1'b0;
        apbWrite(4'h0, 32'h4); mIrqEn = 1'b1;
        @(negedge PCLK);
        chk("irq_idle", 32'(IRQ), 32'd0);
        runTrigPoll(1'b1);
        irqBefore = mNew & mIrqEn;
        apbWrite(4'h4, 32'h2); mNew = 1'b0;
        chk("irq_lag", 32'(IRQ), 32'(irqBefore));
        @(negedge PCLK);
        chk("irq_cleared", 32'(IRQ), 32'(mNew & mIrqEn));

        // Clear landing on the DONE edge: the set wins
        apbWrite(4'h0, 32'h6);
        expStarts++;
        repeat (POLL_LEN - 2) @(negedge PCLK);
        apbWrite(4'h4, 32'h2);
        popPattern(p);
        modelPoll(p);
        apbRead(4'h4, rd);
        chk("new_set_wins", rd, {30'd0, mNew, 1'b0});
        @(negedge PCLK);
        chk("irq_set_wins", 32'(IRQ), 32'(mNew & mIrqEn));

        // Reset in the middle of a poll
        doReset();
        directPattern = 8'h5A;
        apbWrite(4'h0, 32'h2);
        expStarts++;
        rises = 0; prevC = 1'b0;
        for (int g = 0; g < 100 && rises < 3; g++) begin
            @(negedge PCLK);
            if (contCLK && !prevC) rises++;
            prevC = contCLK;
        end
        chk("midreset_reached", 32'(rises), 32'd3);
        PRESET = 1'b1;
        @(negedge PCLK);
        chk("midreset_latch", 32'(contLATCH), 32'd0);
        chk("midreset_clk", 32'(contCLK), 32'd0);
        apbRead(4'h4, rd); chk("midreset_status", rd, 32'd0);
        apbRead(4'h8, rd); chk("midreset_buttons", rd, 32'd0);
        PRESET = 1'b0;
        modelReset();
        if (patQ.size() > 0) void'(patQ.pop_front());

        // Debounce sequence
        seq6[0] = 8'h11; seq6[1] = 8'h22; seq6[2] = 8'h22;
        for (int i = 0; i < 3; i++) begin
            directPattern = seq6[i];
            apbWrite(4'h4, 32'h2); mNew = 1'b0;
            runTrigPoll(1'b0);
        end

        // Randomized triggered polls
        randPad = 1'b1;
        for (int r = 0; r < 8; r++) begin
            if ($urandom_range(0, 1) == 1) begin
                apbWrite(4'h4, 32'h2); mNew = 1'b0;
            end
            runTrigPoll(1'($urandom_range(0, 1)));
        end
        chk("start_count", 32'(totalStarts), 32'(expStarts));

        // Periodic polling with a TRIG issued while busy
        latchStarts.delete();
        apbWrite(4'h0, 32'h1); mEn = 1'b1; mIrqEn = 1'b0;
        for (int pIdx = 0; pIdx < 4; pIdx++) begin
            int g;
            g = 0;
            while (latchStarts.size() <= pIdx && g < int'(2 * POLL_PERIOD)) begin
                @(negedge PCLK);
                g++;
            end
            chk("tick_start", 32'(latchStarts.size() > pIdx), 32'd1);
            if (latchStarts.size() <= pIdx) break;
            if (pIdx == 1) begin
                repeat (10) @(negedge PCLK);
                apbWrite(4'h0, 32'h3);
                repeat (POLL_LEN - 11) @(negedge PCLK);
            end else begin
                repeat (POLL_LEN + 1) @(negedge PCLK);
            end
            popPattern(p);
            modelPoll(p);
            checkRegs();
        end
        apbWrite(4'h0, 32'h0); mEn = 1'b0;
        chk("periodic_count", 32'(latchStarts.size()), 32'd4);
        for (int i = 1; i < latchStarts.size(); i++) begin
            chk("period", 32'(latchStarts[i] - latchStarts[i-1]), 32'(POLL_PERIOD));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
